uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// UART receiver using 16x oversampling. The line is synchronised, a start bit
// is found on a falling edge, and each bit is decided by a 2-of-3 majority
// vote over ticks 7, 8 and 9. Frames are 7 or 8 data bits, LSB first, with
// optional odd/even parity and one stop bit. A received byte is offered to
// the consumer through rx_dout/rx_ready. Parity, framing and overflow errors
// are reported on sticky flags.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   baud_en       one-clk 16x oversample tick
//   rx            asynchronous serial line, idle high
//   bit8          1: 8 data bits, 0: 7 data bits (latched at start bit)
//   parity_en     parity bit present (latched at start bit)
//   odd_n_even    1: odd parity, 0: even parity (latched at start bit)
//   read_rx_byte  one-clk pulse, consumer takes rx_dout
//   clear_err     one-clk pulse, clears the sticky error flags
//   rx_dout       received byte (bit 7 is 0 in 7-bit mode)
//   rx_ready      rx_dout holds an unread byte
//   parity_err    sticky parity error
//   framing_err   sticky framing error (stop bit sampled as 0)
//   overflow      sticky overflow (byte dropped, previous one unread)
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_en,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_err,
    output logic [7:0] rx_dout,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_MID  = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] CNT_S0   = CNT_MID - 4'd2;
    localparam logic [3:0] CNT_S1   = CNT_MID - 4'd1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t  r_state;
    rx_state_t  w_state_next;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [3:0] r_cnt;
    logic       r_samp_a;
    logic       r_samp_b;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_par;
    logic       r_bit8;
    logic       r_par_en;
    logic       r_odd;

    logic [7:0] r_rx_dout;
    logic       r_rx_ready;
    logic       r_parity_err;
    logic       r_framing_err;
    logic       r_overflow;

    logic       w_fall;
    logic       w_tick_mid;
    logic       w_tick_end;
    logic       w_bit;
    logic       w_last_bit;
    logic       w_xfer;
    logic       w_par_set;
    logic       w_frm_set;
    logic       w_drop;
    logic [7:0] w_rx_byte;

    // Two-flop synchroniser plus a delayed copy for edge detection. All reset
    // to 1 so a line held idle never looks like a start bit after reset.
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // A held-low line (break) produces no new falling edge, so the receiver
    // cannot re-arm until rx_s has returned to 1.
    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_tick_mid = baud_en && (r_cnt == CNT_MID);
    assign w_tick_end = baud_en && (r_cnt == CNT_LAST);
    // Majority of the samples at ticks 7, 8 and the live value at tick 9.
    assign w_bit      = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
    assign w_last_bit = (r_bit_idx == (r_bit8 ? 3'd7 : 3'd6));
    // In 7-bit mode the byte has only been shifted seven places.
    assign w_rx_byte  = r_bit8 ? r_shift : {1'b0, r_shift[7:1]};
    assign w_drop     = w_xfer && r_rx_ready && !read_rx_byte;

    always_ff @(posedge clk) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        w_par_set    = 1'b0;
        w_frm_set    = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                if (w_fall) w_state_next = RX_START;
            end
            RX_START: begin
                if (w_tick_mid && w_bit) w_state_next = RX_IDLE;
                else if (w_tick_end)     w_state_next = RX_DATA;
            end
            RX_DATA: begin
                if (w_tick_end && w_last_bit)
                    w_state_next = r_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_tick_mid && (w_bit != (r_odd ^ r_par))) w_par_set = 1'b1;
                if (w_tick_end) w_state_next = RX_STOP;
            end
            RX_STOP: begin
                // Decided half a bit early so the next start edge is not missed.
                if (w_tick_mid) begin
                    w_xfer       = 1'b1;
                    w_frm_set    = ~w_bit;
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Tick counter, samples, shift register and per-frame configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_samp_a  <= 1'b1;
            r_samp_b  <= 1'b1;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_bit8    <= 1'b0;
            r_par_en  <= 1'b0;
            r_odd     <= 1'b0;
        end else if (r_state == RX_IDLE && w_fall) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_bit8    <= bit8;
            r_par_en  <= parity_en;
            r_odd     <= odd_n_even;
        end else if (baud_en) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == CNT_S0) r_samp_a <= r_rx_s;
            if (r_cnt == CNT_S1) r_samp_b <= r_rx_s;
            if (r_state == RX_DATA && r_cnt == CNT_MID) begin
                r_shift <= {w_bit, r_shift[7:1]};
                r_par   <= r_par ^ w_bit;
            end
            if (r_state == RX_DATA && r_cnt == CNT_LAST) r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Consumer handshake and sticky flags. A set later in the block overrides
    // an earlier clear, so a new error wins over a coinciding clear_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_dout     <= '0;
            r_rx_ready    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (!w_drop) begin
                    r_rx_dout  <= w_rx_byte;
                    r_rx_ready <= 1'b1;
                end
            end else if (read_rx_byte) begin
                r_rx_ready <= 1'b0;
            end
            if (clear_err) begin
                r_parity_err  <= 1'b0;
                r_framing_err <= 1'b0;
                r_overflow    <= 1'b0;
            end
            if (w_par_set) r_parity_err  <= 1'b1;
            if (w_frm_set) r_framing_err <= 1'b1;
            if (w_drop)    r_overflow    <= 1'b1;
        end
    end

    assign rx_dout     = r_rx_dout;
    assign rx_ready    = r_rx_ready;
    assign parity_err  = r_parity_err;
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Directed bench for uart_rx_sampler. Frames are driven bit by bit on rx;
// the expected output state for each step is pushed to a scoreboard queue
// when the stimulus is issued and popped when the outputs are compared.
// baud_en ticks once every 4 clocks, so one bit lasts 64 clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] dout;
        logic       ready;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       baud_en;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic       clear_err;
    logic [7:0] rx_dout;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   baud_div = 0;
    exp_t sb_q[$];

    uart_rx_sampler #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_en      (baud_en),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .clear_err    (clear_err),
        .rx_dout      (rx_dout),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running oversample tick: high for one clock in four.
    initial begin
        baud_en = 1'b0;
        forever begin
            @(negedge clk);
            baud_en  = (baud_div == 3);
            baud_div = (baud_div + 1) % 4;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: observed run still active, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed 0x%0h required 0x%0h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic rdy, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.dout  = d;
        e.ready = rdy;
        e.perr  = pe;
        e.ferr  = fe;
        e.ovf   = ov;
        sb_q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check(tag, "sb_entry", 8'(sb_q.size() > 0), 8'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(tag, "rx_dout",     rx_dout,            e.dout);
            check(tag, "rx_ready",    8'(rx_ready),       8'(e.ready));
            check(tag, "parity_err",  8'(parity_err),     8'(e.perr));
            check(tag, "framing_err", 8'(framing_err),    8'(e.ferr));
            check(tag, "overflow",    8'(overflow),       8'(e.ovf));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start the next bit cell on the negedge right after a baud tick, which
    // fixes where the receiver's stop-bit decision lands (39 clocks into the
    // stop bit).
    task automatic align();
        @(posedge clk);
        while (!baud_en) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_read();
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    // stop_pulse: 0 none, 1 read_rx_byte, 2 clear_err, on the stop-decision clock.
    task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen, input bit odd,
                              input bit bad_par, input bit stop_val, input bit flip_cfg,
                              input int stop_pulse);
        int   nb;
        logic p;
        nb         = b8 ? 8 : 7;
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        p = odd;
        for (int i = 0; i < nb; i++) p = p ^ data[i];
        p = p ^ bad_par;
        align();
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        if (flip_cfg) begin
            bit8       = ~b8;
            parity_en  = ~pen;
            odd_n_even = ~odd;
        end
        for (int i = 0; i < nb; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        if (pen) begin
            rx = p;
            wait_clks(BIT_CLKS);
        end
        rx = stop_val;
        if (stop_pulse != 0) begin
            wait_clks(39);
            if (stop_pulse == 1) read_rx_byte = 1'b1;
            else                 clear_err    = 1'b1;
            @(negedge clk);
            read_rx_byte = 1'b0;
            clear_err    = 1'b0;
            wait_clks(BIT_CLKS - 40);
        end else begin
            wait_clks(BIT_CLKS);
        end
        rx         = 1'b1;
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        wait_clks(8);
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        bit8         = 1'b1;
        parity_en    = 1'b0;
        odd_n_even   = 1'b0;
        read_rx_byte = 1'b0;
        clear_err    = 1'b0;
        wait_clks(4);
        reset = 1'b0;
        push(8'h00, 0, 0, 0, 0);
        compare("reset");
        wait_clks(10);

        // 8N1 0xA5; config pins toggled mid-frame must be ignored.
        push(8'hA5, 1, 0, 0, 0);
        send_frame(8'hA5, 1, 0, 0, 0, 1, 1, 0);
        compare("8n1_a5");
        pulse_read();
        push(8'hA5, 0, 0, 0, 0);
        compare("read_a5");
        pulse_read();
        push(8'hA5, 0, 0, 0, 0);
        compare("read_when_empty");

        // 7E1 0x35, good parity then flipped parity.
        push(8'h35, 1, 0, 0, 0);
        send_frame(8'h35, 0, 1, 0, 0, 1, 0, 0);
        compare("7e1_good");
        pulse_read();
        push(8'h35, 1, 1, 0, 0);
        send_frame(8'h35, 0, 1, 0, 1, 1, 0, 0);
        compare("7e1_bad_parity");
        pulse_read();
        pulse_clear();
        push(8'h35, 0, 0, 0, 0);
        compare("clear_err");

        // 8O1 0xC3 with correct odd parity.
        push(8'hC3, 1, 0, 0, 0);
        send_frame(8'hC3, 1, 1, 1, 0, 1, 0, 0);
        compare("8o1_good");
        pulse_read();

        // 4-tick glitch in idle: false start.
        align();
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(200);
        push(8'hC3, 0, 0, 0, 0);
        compare("false_start");

        // Stop bit forced low.
        push(8'h3C, 1, 0, 1, 0);
        send_frame(8'h3C, 1, 0, 0, 0, 0, 0, 0);
        compare("framing");
        pulse_read();
        pulse_clear();

        // Overflow: two frames, no read.
        push(8'h11, 1, 0, 0, 0);
        send_frame(8'h11, 1, 0, 0, 0, 1, 0, 0);
        compare("ovf_first");
        push(8'h11, 1, 0, 0, 1);
        send_frame(8'h22, 1, 0, 0, 0, 1, 0, 0);
        compare("ovf_second");
        pulse_read();
        pulse_clear();
        push(8'h11, 0, 0, 0, 0);
        compare("ovf_cleared");

        // Read coinciding with the second transfer.
        push(8'h11, 1, 0, 0, 0);
        send_frame(8'h11, 1, 0, 0, 0, 1, 0, 0);
        compare("coinc_first");
        push(8'h22, 1, 0, 0, 0);
        send_frame(8'h22, 1, 0, 0, 0, 1, 0, 1);
        compare("read_coincide");
        pulse_read();

        // clear_err on the same clock as a framing error: the set wins.
        push(8'h7E, 1, 0, 1, 0);
        send_frame(8'h7E, 1, 0, 0, 0, 0, 0, 2);
        compare("clear_vs_set");
        pulse_read();
        pulse_clear();

        // Reset after 3 data bits, with an overflow pending beforehand.
        push(8'h33, 1, 0, 0, 0);
        send_frame(8'h33, 1, 0, 0, 0, 1, 0, 0);
        compare("pre_reset_a");
        push(8'h33, 1, 0, 0, 1);
        send_frame(8'h44, 1, 0, 0, 0, 1, 0, 0);
        compare("pre_reset_b");
        align();
        rx = 1'b0;
        wait_clks(4 * BIT_CLKS);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        push(8'h00, 0, 0, 0, 0);
        compare("mid_frame_reset");
        wait_clks(100);
        push(8'h00, 0, 0, 0, 0);
        compare("after_reset_idle");
        push(8'h5A, 1, 0, 0, 0);
        send_frame(8'h5A, 1, 0, 0, 0, 1, 0, 0);
        compare("after_reset_5a");
        pulse_read();

        // Break: one framing error and one 0x00 transfer, no re-arm while low.
        bit8      = 1'b1;
        parity_en = 1'b0;
        push(8'h00, 1, 0, 1, 0);
        align();
        rx = 1'b0;
        wait_clks(700);
        compare("break");
        pulse_read();
        pulse_clear();
        wait_clks(1400);
        push(8'h00, 0, 0, 0, 0);
        compare("break_hold");
        rx = 1'b1;
        wait_clks(20);
        push(8'h81, 1, 0, 0, 0);
        send_frame(8'h81, 1, 0, 0, 0, 1, 0, 0);
        compare("after_break");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
